// File: rtl/pipeline_stall_controller_pkg.sv
// Shared encodings and widths for the pipeline stall/flush sequencer.
// The state values are fixed so that debug traces match the core's documentation.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_ERROR    = 2'd3
    } stall_state_t;

    localparam int STALL_CNT_LEN_DEF = 16;
    localparam int MEM_WAIT_CNT_LEN  = 8;
    localparam int FLUSH_CNT_LEN     = 2;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Clear is synchronous and active-low so it can share the core reset directly.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush sequencer: memory wait beats taken branch beats load-use hazard.
// Outputs are decoded combinationally so every response lands in the cycle of its cause.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int MEM_TIMEOUT   = 64,
    parameter int STALL_CNT_LEN = STALL_CNT_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hazard_detected,
    input  logic                     branch_taken,
    input  logic                     mem_req,
    input  logic                     mem_ready,
    output logic                     pc_freeze,
    output logic                     if_id_freeze,
    output logic                     if_id_flush,
    output logic                     id_exe_freeze,
    output logic                     id_exe_flush,
    output logic                     exe_mem_freeze,
    output logic                     mem_wb_bubble,
    output logic                     mem_timeout,
    output logic [STALL_CNT_LEN-1:0] stall_count
);

    localparam logic [MEM_WAIT_CNT_LEN-1:0] WAIT_LAST  = MEM_WAIT_CNT_LEN'(MEM_TIMEOUT - 1);
    localparam logic [FLUSH_CNT_LEN-1:0]    FLUSH_INIT = FLUSH_CNT_LEN'(FLUSH_CYCLES - 1);

    stall_state_t                state_q, state_d;
    logic [MEM_WAIT_CNT_LEN-1:0] wait_q, wait_d;
    logic [FLUSH_CNT_LEN-1:0]    flush_q, flush_d;
    logic                        timeout_q, timeout_d;

    logic mem_stall;
    logic freeze_all;
    logic use_run_rules;
    logic pc_fz, if_id_fz, if_id_fl, id_exe_fl;

    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        flush_d       = flush_q;
        timeout_d     = timeout_q;
        freeze_all    = 1'b0;
        use_run_rules = 1'b0;
        pc_fz         = 1'b0;
        if_id_fz      = 1'b0;
        if_id_fl      = 1'b0;
        id_exe_fl     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze_all = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_d     = MEM_WAIT_CNT_LEN'(1);
                end else begin
                    use_run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze_all = 1'b1;
                    wait_d     = wait_q + MEM_WAIT_CNT_LEN'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end
                end else begin
                    use_run_rules = 1'b1;
                    state_d       = ST_RUN;
                    wait_d        = '0;
                end
            end
            ST_BR_FLUSH: begin
                // flush_cnt is held across a memory stall; the fetch unit owns any bubbles left after it
                if (mem_stall) begin
                    freeze_all = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_d     = MEM_WAIT_CNT_LEN'(1);
                end else begin
                    if_id_fl = 1'b1;
                    flush_d  = flush_q - FLUSH_CNT_LEN'(1);
                    if (flush_q == FLUSH_CNT_LEN'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                freeze_all = 1'b1;
            end
        endcase

        if (use_run_rules) begin
            if (branch_taken) begin
                if_id_fl  = 1'b1;
                id_exe_fl = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_BR_FLUSH;
                    flush_d = FLUSH_INIT;
                end
            end else if (hazard_detected) begin
                pc_fz     = 1'b1;
                if_id_fz  = 1'b1;
                id_exe_fl = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    // Pipeline controls are masked for the whole time reset is held low.
    assign pc_freeze      = rst & (freeze_all | pc_fz);
    assign if_id_freeze   = rst & (freeze_all | if_id_fz);
    assign if_id_flush    = rst & if_id_fl;
    assign id_exe_freeze  = rst & freeze_all;
    assign id_exe_flush   = rst & id_exe_fl;
    assign exe_mem_freeze = rst & freeze_all;
    assign mem_wb_bubble  = rst & freeze_all;
    assign mem_timeout    = timeout_q;

    sat_counter #(
        .WIDTH(STALL_CNT_LEN)
    ) u_stall_cnt (
        .clk  (clk),
        .clr_n(rst),
        .en   (pc_freeze),
        .count(stall_count)
    );

endmodule
